inst_seq_ctrl: RTL and testbench

INST_SEQ_CTRL -- requirements
Module: inst_seq_ctrl

---
 rtl/param_pkg.sv | 52 +++++
 rtl/mem_wdt.sv | 36 +++
 rtl/inst_seq_ctrl.sv | 162 ++++++++++++++++
 tb/tb_inst_seq_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/param_pkg.sv
// Shared constants for the instruction sequencer: FSM states,
// trap causes, decoder class codes and opcode values.
package param_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  localparam logic [3:0] CAUSE_IF_TO    = 4'd1;
  localparam logic [3:0] CAUSE_ILLEGAL  = 4'd2;
  localparam logic [3:0] CAUSE_BREAK    = 4'd3;
  localparam logic [3:0] CAUSE_LD_TO    = 4'd5;
  localparam logic [3:0] CAUSE_ST_TO    = 4'd7;
  localparam logic [3:0] CAUSE_IRQ      = 4'd8;
  localparam logic [3:0] CAUSE_ECALL    = 4'd11;

  // Class codes reported by the decoder on i_inst_typ
  localparam logic [6:0] TYP_UNK = 7'd0;
  localparam logic [6:0] TYP_R   = 7'd1;
  localparam logic [6:0] TYP_I   = 7'd2;
  localparam logic [6:0] TYP_S   = 7'd3;
  localparam logic [6:0] TYP_B   = 7'd4;
  localparam logic [6:0] TYP_U   = 7'd5;
  localparam logic [6:0] TYP_J   = 7'd6;
  localparam logic [6:0] TYP_CSR = 7'd7;
  localparam logic [6:0] TYP_F   = 7'd8;
  localparam logic [6:0] TYP_SYS = 7'd9;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] PC_SEQ  = 2'd0;
  localparam logic [1:0] PC_TGT  = 2'd1;
  localparam logic [1:0] PC_TRAP = 2'd2;

  function automatic logic typ_writes_rd(input logic [6:0] typ);
    return typ inside {TYP_R, TYP_I, TYP_U, TYP_J, TYP_CSR};
  endfunction

endpackage

// File: rtl/mem_wdt.sv
// Wait-cycle watchdog for imem/dmem handshakes.
// expired_o flags the last permitted cycle without an ack.
module mem_wdt #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic count_i,
  output logic expired_o
);

  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = count_i && (cnt_q == LAST);

endmodule

// File: rtl/inst_seq_ctrl.sv
// Multi-cycle instruction sequencer: fetch, decode, execute,
// memory, writeback and trap control with retire counting.
module inst_seq_ctrl
  import param_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_en,
  output logic [2:0]      o_state,
  output logic            o_imem_req,
  input  logic            i_imem_ack,
  input  logic [XLEN-1:0] i_instr,
  output logic [XLEN-1:0] o_ir,
  output logic            o_dec_en,
  input  logic [6:0]      i_inst_typ,
  input  logic [6:0]      i_opcode,
  input  logic            i_br_taken,
  output logic            o_alu_en,
  output logic            o_dmem_req,
  output logic            o_dmem_we,
  input  logic            i_dmem_ack,
  output logic            o_rf_we,
  output logic            o_pc_we,
  output logic            o_retire,
  output logic            o_trap,
  output logic [1:0]      o_pc_sel,
  output logic [3:0]      o_trap_cause,
  output logic [XLEN-1:0] o_instret,
  input  logic            i_irq
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] ir_q, instret_q;
  logic [6:0]      typ_q, op_q;
  logic            taken_q;
  logic [3:0]      cause_q, cause_d;
  logic            in_wait, ack, wdt_exp;

  assign in_wait = (state_q == S_FETCH) || (state_q == S_MEM);
  assign ack     = (state_q == S_FETCH) ? i_imem_ack : i_dmem_ack;

  // Held at zero outside FETCH/MEM, so each entry starts fresh
  mem_wdt #(.LIMIT(MEM_TIMEOUT)) u_wdt (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .clear_i  (!in_wait),
    .count_i  (in_wait && !ack),
    .expired_o(wdt_exp)
  );

  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    o_imem_req = 1'b0;
    o_dec_en   = 1'b0;
    o_alu_en   = 1'b0;
    o_dmem_req = 1'b0;
    o_dmem_we  = 1'b0;
    o_rf_we    = 1'b0;
    o_pc_we    = 1'b0;
    o_retire   = 1'b0;
    o_trap     = 1'b0;
    o_pc_sel   = PC_SEQ;
    unique case (state_q)
      S_IDLE: begin
        if (i_en) state_d = S_FETCH;
      end
      S_FETCH: begin
        o_imem_req = 1'b1;
        if (i_imem_ack) begin
          state_d = S_DECODE;
        end else if (wdt_exp) begin
          state_d = S_TRAP;
          cause_d = CAUSE_IF_TO;
        end
      end
      S_DECODE: begin
        o_dec_en = 1'b1;
        if (i_inst_typ == TYP_UNK) begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else if (i_inst_typ == TYP_SYS &&
                     ir_q[14:12] == 3'd0) begin
          state_d = S_TRAP;
          cause_d = ir_q[20] ? CAUSE_BREAK : CAUSE_ECALL;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        o_alu_en = 1'b1;
        if (typ_q == TYP_S || op_q == OP_LOAD) state_d = S_MEM;
        else                                   state_d = S_WB;
      end
      S_MEM: begin
        o_dmem_req = 1'b1;
        o_dmem_we  = (typ_q == TYP_S);
        if (i_dmem_ack) begin
          state_d = S_WB;
        end else if (wdt_exp) begin
          state_d = S_TRAP;
          cause_d = (typ_q == TYP_S) ? CAUSE_ST_TO : CAUSE_LD_TO;
        end
      end
      S_WB: begin
        o_pc_we  = 1'b1;
        o_retire = 1'b1;
        o_rf_we  = typ_writes_rd(typ_q);
        if (typ_q == TYP_J || op_q == OP_JALR ||
            (typ_q == TYP_B && taken_q)) begin
          o_pc_sel = PC_TGT;
        end
        if (i_irq) begin
          state_d = S_TRAP;
          cause_d = CAUSE_IRQ;
        end else if (i_en) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_TRAP: begin
        o_trap   = 1'b1;
        o_pc_we  = 1'b1;
        o_pc_sel = PC_TRAP;
        state_d  = i_en ? S_FETCH : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      instret_q <= '0;
      cause_q   <= '0;
      typ_q     <= TYP_UNK;
      op_q      <= '0;
      taken_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      if (state_q == S_FETCH && i_imem_ack) ir_q <= i_instr;
      if (state_q == S_DECODE) begin
        typ_q <= i_inst_typ;
        op_q  <= i_opcode;
      end
      if (state_q == S_EXEC) taken_q <= i_br_taken;
      if (state_q == S_WB) instret_q <= instret_q + XLEN'(1);
    end
  end

  assign o_state      = state_q;
  assign o_ir         = ir_q;
  assign o_instret    = instret_q;
  assign o_trap_cause = cause_q;

endmodule

// File: tb/tb_inst_seq_ctrl.sv
// Scoreboard bench for inst_seq_ctrl: retire/trap events are
// queued at issue and matched when the DUT strobes them.
module tb_inst_seq_ctrl;
  import param_pkg::*;

  localparam int TO = 255;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_en = 1'b0;
  logic        i_imem_ack = 1'b0;
  logic [31:0] i_instr = '0;
  logic [6:0]  i_inst_typ = '0;
  logic [6:0]  i_opcode = '0;
  logic        i_br_taken = 1'b0;
  logic        i_dmem_ack = 1'b0;
  logic        i_irq = 1'b0;

  logic [2:0]  o_state;
  logic        o_imem_req, o_dec_en, o_alu_en;
  logic        o_dmem_req, o_dmem_we;
  logic        o_rf_we, o_pc_we, o_retire, o_trap;
  logic [1:0]  o_pc_sel;
  logic [3:0]  o_trap_cause;
  logic [31:0] o_ir, o_instret;

  inst_seq_ctrl #(.XLEN(32), .MEM_TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en),
    .o_state(o_state), .o_imem_req(o_imem_req),
    .i_imem_ack(i_imem_ack), .i_instr(i_instr), .o_ir(o_ir),
    .o_dec_en(o_dec_en), .i_inst_typ(i_inst_typ),
    .i_opcode(i_opcode), .i_br_taken(i_br_taken),
    .o_alu_en(o_alu_en), .o_dmem_req(o_dmem_req),
    .o_dmem_we(o_dmem_we), .i_dmem_ack(i_dmem_ack),
    .o_rf_we(o_rf_we), .o_pc_we(o_pc_we), .o_retire(o_retire),
    .o_trap(o_trap), .o_pc_sel(o_pc_sel),
    .o_trap_cause(o_trap_cause), .o_instret(o_instret),
    .i_irq(i_irq)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic       trap;
    logic [3:0] cause;
    logic       rf_we;
    logic [1:0] pc_sel;
  } ev_t;

  ev_t         sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] inst_m = '0;
  logic [3:0]  cause_m = '0;

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic ev_t mk(input logic t, input logic [3:0] c,
                             input logic rf, input logic [1:0] ps);
    ev_t e;
    e.trap = t;
    e.cause = c;
    e.rf_we = rf;
    e.pc_sel = ps;
    return e;
  endfunction

  function automatic logic exp_rf_we(input logic [6:0] t);
    return t == TYP_R || t == TYP_I || t == TYP_U ||
           t == TYP_J || t == TYP_CSR;
  endfunction

  always @(negedge i_clk) begin : mon
    ev_t e;
    if (i_rst_n && (o_retire || o_trap)) begin
      if (sb.size() == 0) begin
        chk("sb_depth", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("ev_trap", 32'(o_trap), 32'(e.trap));
        chk("ev_retire", 32'(o_retire), 32'(!e.trap));
        chk("ev_pc_we", 32'(o_pc_we), 32'd1);
        chk("ev_pc_sel", 32'(o_pc_sel), 32'(e.pc_sel));
        chk("ev_rf_we", 32'(o_rf_we), 32'(e.rf_we));
        if (e.trap) begin
          chk("ev_cause", 32'(o_trap_cause), 32'(e.cause));
          cause_m = e.cause;
        end else begin
          inst_m = inst_m + 32'd1;
        end
      end
    end
  end

  task automatic wait_fetch();
    int n;
    n = 0;
    while (o_state != 3'd1 && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    chk("fetch_reach", 32'(o_state), 32'd1);
  endtask

  task automatic run_instr(input logic [31:0] ins,
                           input logic [6:0] typ,
                           input logic [6:0] op,
                           input int iw, input int dw,
                           input logic tk, input logic irq,
                           input logic drop);
    logic       mem, dtrap, mto;
    logic [3:0] dc;
    logic [1:0] ps;
    int         cyc;
    mem   = (typ == TYP_S) || (op == OP_LOAD);
    dtrap = 1'b0;
    dc    = 4'd2;
    if (typ == TYP_UNK) begin
      dtrap = 1'b1;
    end else if (typ == TYP_SYS && ins[14:12] == 3'd0) begin
      dtrap = 1'b1;
      dc = ins[20] ? 4'd3 : 4'd11;
    end
    mto = mem && (dw >= TO);
    ps = (typ == TYP_J || op == OP_JALR ||
          (typ == TYP_B && tk)) ? 2'd1 : 2'd0;
    if (dtrap) begin
      sb.push_back(mk(1'b1, dc, 1'b0, 2'd2));
    end else if (mto) begin
      sb.push_back(mk(1'b1, (typ == TYP_S) ? 4'd7 : 4'd5,
                      1'b0, 2'd2));
    end else begin
      sb.push_back(mk(1'b0, 4'd0, exp_rf_we(typ), ps));
      if (irq) sb.push_back(mk(1'b1, 4'd8, 1'b0, 2'd2));
    end
    wait_fetch();
    chk("imem_req", 32'(o_imem_req), 32'd1);
    i_instr = ins;
    i_inst_typ = typ;
    i_opcode = op;
    cyc = 1;
    repeat (iw) begin
      @(negedge i_clk);
      cyc++;
    end
    i_imem_ack = 1'b1;
    @(negedge i_clk);
    cyc++;
    i_imem_ack = 1'b0;
    i_irq = 1'b1;
    chk("dec_state", 32'(o_state), 32'd2);
    chk("dec_en", 32'(o_dec_en), 32'd1);
    chk("ir", o_ir, ins);
    if (drop) i_en = 1'b0;
    @(negedge i_clk);
    cyc++;
    if (dtrap) begin
      chk("dtrap_state", 32'(o_state), 32'd6);
      chk("dtrap_instret", o_instret, inst_m);
    end else begin
      chk("exec_state", 32'(o_state), 32'd3);
      chk("alu_en", 32'(o_alu_en), 32'd1);
      i_br_taken = tk;
      @(negedge i_clk);
      cyc++;
      i_br_taken = 1'b0;
      if (mem) begin
        chk("mem_state", 32'(o_state), 32'd4);
        chk("dmem_req", 32'(o_dmem_req), 32'd1);
        chk("dmem_we", 32'(o_dmem_we), 32'(typ == TYP_S));
        if (mto) begin
          repeat (TO) @(negedge i_clk);
          chk("mto_state", 32'(o_state), 32'd6);
        end else begin
          repeat (dw) begin
            @(negedge i_clk);
            cyc++;
          end
          i_dmem_ack = 1'b1;
          @(negedge i_clk);
          cyc++;
          i_dmem_ack = 1'b0;
        end
      end
      if (!mto) begin
        chk("wb_state", 32'(o_state), 32'd5);
        chk("latency", 32'(cyc),
            32'(4 + iw + (mem ? 1 + dw : 0)));
        chk("cause_hold", 32'(o_trap_cause), 32'(cause_m));
        i_irq = irq;
        @(negedge i_clk);
        chk("instret", o_instret, inst_m);
        if (irq) chk("irq_state", 32'(o_state), 32'd6);
      end
    end
    i_irq = 1'b0;
    if (drop) begin
      if (o_state == 3'd6) @(negedge i_clk);
      chk("park_idle", 32'(o_state), 32'd0);
    end
  endtask

  task automatic fetch_timeout();
    wait_fetch();
    sb.push_back(mk(1'b1, 4'd1, 1'b0, 2'd2));
    i_imem_ack = 1'b0;
    repeat (TO - 1) @(negedge i_clk);
    chk("ifto_pre", 32'(o_state), 32'd1);
    @(negedge i_clk);
    chk("ifto_state", 32'(o_state), 32'd6);
    chk("ifto_instret", o_instret, inst_m);
    @(negedge i_clk);
  endtask

  task automatic reset_mid_mem();
    wait_fetch();
    i_instr = 32'h0020A023;
    i_inst_typ = TYP_S;
    i_opcode = OP_STORE;
    i_imem_ack = 1'b1;
    @(negedge i_clk);
    i_imem_ack = 1'b0;
    repeat (2) @(negedge i_clk);
    chk("mm_state", 32'(o_state), 32'd4);
    chk("mm_req", 32'(o_dmem_req), 32'd1);
    i_rst_n = 1'b0;
    #1;
    chk("mm_rst_req", 32'(o_dmem_req), 32'd0);
    chk("mm_rst_state", 32'(o_state), 32'd0);
    chk("mm_rst_instret", o_instret, 32'd0);
    chk("mm_rst_ir", o_ir, 32'd0);
    chk("mm_rst_cause", 32'(o_trap_cause), 32'd0);
    inst_m = '0;
    cause_m = '0;
    i_en = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_dmem_ack = 1'b1;
    i_imem_ack = 1'b1;
    repeat (2) @(negedge i_clk);
    chk("mm_ack_ignored", 32'(o_state), 32'd0);
    chk("mm_instret_hold", o_instret, 32'd0);
    i_dmem_ack = 1'b0;
    i_imem_ack = 1'b0;
    i_en = 1'b1;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    @(negedge i_clk);
    chk("rst_state", 32'(o_state), 32'd0);
    chk("rst_imem_req", 32'(o_imem_req), 32'd0);
    chk("rst_pc_sel", 32'(o_pc_sel), 32'd0);
    chk("rst_instret", o_instret, 32'd0);
    chk("rst_ir", o_ir, 32'd0);
    chk("rst_cause", 32'(o_trap_cause), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);
    chk("idle_hold", 32'(o_state), 32'd0);
    i_en = 1'b1;

    run_instr(32'h00500093, TYP_I, OP_OPIMM, 0, 0, 0, 0, 0);
    run_instr(32'h002081B3, TYP_R, OP_OP, 2, 0, 0, 0, 0);
    run_instr(32'h0020A023, TYP_S, OP_STORE, 0, 3, 0, 0, 0);
    run_instr(32'h0000A183, TYP_I, OP_LOAD, 1, 0, 0, 0, 0);
    run_instr(32'h00208463, TYP_B, OP_BRANCH, 0, 0, 1, 0, 0);
    run_instr(32'h00208463, TYP_B, OP_BRANCH, 0, 0, 0, 0, 0);
    run_instr(32'h008000EF, TYP_J, OP_JAL, 0, 0, 0, 0, 0);
    run_instr(32'h000080E7, TYP_I, OP_JALR, 0, 0, 0, 0, 0);
    run_instr(32'h34029073, TYP_CSR, OP_SYSTEM, 0, 0, 0, 0, 0);
    run_instr(32'h00000000, TYP_UNK, 7'd0, 0, 0, 0, 0, 0);
    run_instr(32'h00000073, TYP_SYS, OP_SYSTEM, 0, 0, 0, 0, 0);
    run_instr(32'h00100073, TYP_SYS, OP_SYSTEM, 0, 0, 0, 0, 0);
    run_instr(32'h00208463, TYP_B, OP_BRANCH, 0, 0, 1, 1, 0);
    fetch_timeout();
    run_instr(32'h00500093, TYP_I, OP_OPIMM, TO - 1, 0, 0, 0, 0);
    run_instr(32'h0020A023, TYP_S, OP_STORE, 0, TO, 0, 0, 0);
    run_instr(32'h0000A183, TYP_I, OP_LOAD, 0, TO, 0, 0, 0);
    run_instr(32'h0000A183, TYP_I, OP_LOAD, 0, TO - 1, 0, 0, 0);
    run_instr(32'h00500093, TYP_I, OP_OPIMM, 0, 0, 0, 0, 1);
    repeat (3) @(negedge i_clk);
    chk("idle_hold2", 32'(o_state), 32'd0);
    i_en = 1'b1;
    reset_mid_mem();
    run_instr(32'h00500093, TYP_I, OP_OPIMM, 0, 0, 0, 0, 0);
    repeat (2) @(negedge i_clk);
    chk("sb_left", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
